uart_rx_fifo: RTL and testbench

//   Receive-side byte buffer placed directly downstream of the UART receiver.
//   - Captures each received byte when the receiver pulses rx_done_tick.
//   - Lets the host/bus side drain bytes at its own pace.
//   - Reports empty, full and fill level, plus a sticky overflow flag.

---
 rtl/uart_rx_fifo.sv | 104 ++++++++++
 tb/tb_uart_rx_fifo.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO behind the UART receiver: FWFT read, level counter, sticky overflow.
// Build option UART_RXF_OVERWRITE_EN: a write while full discards the oldest entry instead of the new word.
module uart_rx_fifo #(
   parameter int DBIT   = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr,
   input  logic [DBIT-1:0]   w_data,
   input  logic              rd,
   output logic [DBIT-1:0]   r_data,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   level,
   output logic              overflow,
   input  logic              ovf_clr
);

   localparam int              DEPTH   = 2**ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];
   localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   LVL_ONE = {{ADDR_W{1'b0}}, 1'b1};

   logic [DBIT-1:0]   mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   level_q, level_d;
   logic              ovf_q, ovf_d;
   logic              mem_we;
   logic              ovf_set;

   assign empty    = (level_q == '0);
   assign full     = (level_q == DEPTH_L);
   assign level    = level_q;
   assign overflow = ovf_q;
   assign r_data   = empty ? '0 : mem_q[rd_ptr_q];

   // wr and rd are single-cycle strobes: each cycle a strobe is high at a rising edge
   // counts as exactly one write or pop; there is no back-pressure on either side.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      ovf_d    = ovf_q;
      mem_we   = 1'b0;
      ovf_set  = 1'b0;

      if (wr && rd) begin
         mem_we   = 1'b1;
         wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (!empty) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end else begin
            level_d = level_q + LVL_ONE;
         end
      end else if (wr) begin
         if (!full) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            level_d  = level_q + LVL_ONE;
         end else begin
            ovf_set = 1'b1;
`ifdef UART_RXF_OVERWRITE_EN
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            rd_ptr_d = rd_ptr_q + PTR_ONE;
`endif
         end
      end else if (rd && !empty) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
         level_d  = level_q - LVL_ONE;
      end

      // A new overflow event outranks a simultaneous clear.
      if (ovf_set) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (reset_n && mem_we) begin
         mem_q[wr_ptr_q] <= w_data;
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: drivers push expected bytes into exp_q, a negedge monitor checks pops.
module tb_uart_rx_fifo;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       wr = 1'b0;
   logic       rd = 1'b0;
   logic       ovf_clr = 1'b0;
   logic [7:0] w_data = 8'h00;
   logic [7:0] r_data;
   logic       empty, full, overflow;
   logic [4:0] level;

   int checks = 0;
   int failures = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   uart_rx_fifo #(.DBIT(8), .ADDR_W(4)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr       (wr),
      .w_data   (w_data),
      .rd       (rd),
      .r_data   (r_data),
      .empty    (empty),
      .full     (full),
      .level    (level),
      .overflow (overflow),
      .ovf_clr  (ovf_clr)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_lvl(input string name, input int lvl);
      check({name, " level"}, 32'(level), 32'(lvl));
      check({name, " empty"}, 32'(empty), 32'(lvl == 0));
      check({name, " full"},  32'(full),  32'(lvl == 16));
   endtask

   // Called at posedge+1; inputs are held across exactly one rising edge.
   task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic c);
      wr = w; w_data = d; rd = r; ovf_clr = c;
      @(posedge clk);
      #1;
      wr = 1'b0; rd = 1'b0; ovf_clr = 1'b0; w_data = 8'h00;
   endtask

   task automatic push(input logic [7:0] d);
      exp_q.push_back(d);
      drive(1'b1, d, 1'b0, 1'b0);
   endtask

   task automatic pop();
      drive(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   // Monitor: the head word is on r_data whenever a pop is about to be taken.
   always @(negedge clk) begin
      if (reset_n && rd && !empty) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pop_data: got 0x%0h expected no pop", r_data);
         end else begin
            check("pop_data", 32'(r_data), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      logic [7:0] d;
      int lvl;

      repeat (2) @(posedge clk);
      #1;
      check_lvl("reset", 0);
      check("reset overflow", 32'(overflow), 32'd0);
      check("reset r_data", 32'(r_data), 32'd0);
      reset_n = 1'b1;

      // Three pushes, then three pops in order.
      push(8'h11); push(8'h22); push(8'h33);
      check_lvl("t1 after push", 3);
      check("t1 head", 32'(r_data), 32'h11);
      pop();
      check("t1 head after pop1", 32'(r_data), 32'h22);
      pop();
      check("t1 head after pop2", 32'(r_data), 32'h33);
      pop();
      check_lvl("t1 drained", 0);
      check("t1 r_data empty", 32'(r_data), 32'd0);

      // Fill to 16, then one write while full.
      for (int i = 0; i < 16; i++) push(8'(i));
      check_lvl("t2 filled", 16);
      check("t2 overflow before", 32'(overflow), 32'd0);
`ifdef UART_RXF_OVERWRITE_EN
      void'(exp_q.pop_front());
      exp_q.push_back(8'hAA);
      drive(1'b1, 8'hAA, 1'b0, 1'b0);
      check("t2 head after overwrite", 32'(r_data), 32'h01);
`else
      drive(1'b1, 8'hAA, 1'b0, 1'b0);
      check("t2 head after drop", 32'(r_data), 32'h00);
`endif
      check_lvl("t2 after full write", 16);
      check("t2 overflow set", 32'(overflow), 32'd1);
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      check("t2 overflow cleared", 32'(overflow), 32'd0);

      // Simultaneous write and read while full: no overflow.
      exp_q.push_back(8'h55);
      drive(1'b1, 8'h55, 1'b1, 1'b0);
      check_lvl("t3 wr+rd full", 16);
      check("t3 overflow", 32'(overflow), 32'd0);
      for (int i = 0; i < 16; i++) pop();
      check_lvl("t3 drained", 0);
      check("t3 queue consumed", 32'(exp_q.size()), 32'd0);

      // Simultaneous write and read while empty.
      exp_q.push_back(8'h77);
      drive(1'b1, 8'h77, 1'b1, 1'b0);
      check_lvl("t4 wr+rd empty", 1);
      check("t4 head", 32'(r_data), 32'h77);
      pop();
      check_lvl("t4 popped", 0);
      pop();
      check_lvl("t4 rd on empty", 0);
      check("t4 overflow", 32'(overflow), 32'd0);
      check("t4 r_data", 32'(r_data), 32'd0);

      // 20 words per round, three rounds, pointers wrap repeatedly.
      for (int r = 0; r < 3; r++) begin
         lvl = 0;
         for (int i = 0; i < 10; i++) begin
            d = 8'(8'h20 + r * 20 + i);
            push(d);
            lvl++;
            check("t5 level rise", 32'(level), 32'(lvl));
         end
         for (int i = 10; i < 20; i++) begin
            d = 8'(8'h20 + r * 20 + i);
            exp_q.push_back(d);
            drive(1'b1, d, 1'b1, 1'b0);
            check("t5 level steady", 32'(level), 32'(lvl));
         end
         for (int i = 0; i < 10; i++) begin
            pop();
            lvl--;
            check("t5 level fall", 32'(level), 32'(lvl));
         end
         check("t5 round consumed", 32'(exp_q.size()), 32'd0);
      end

      // Clear coinciding with a full-write: set wins.
      for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
`ifdef UART_RXF_OVERWRITE_EN
      void'(exp_q.pop_front());
      exp_q.push_back(8'hEE);
`endif
      drive(1'b1, 8'hEE, 1'b0, 1'b1);
      check("t5 set beats clear", 32'(overflow), 32'd1);
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      check("t5 clear alone", 32'(overflow), 32'd0);
      for (int i = 0; i < 11; i++) pop();
      check_lvl("t6 before reset", 5);

      // Reset mid-stream.
      exp_q.delete();
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      check_lvl("t6 after reset", 0);
      check("t6 overflow", 32'(overflow), 32'd0);
      check("t6 r_data", 32'(r_data), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
